// File: rtl/ud_counter_param.sv
// ud_counter_param: parametrised up/down counter with modulus MAX_VAL+1,
// synchronous clamped load, combinational terminal count and a registered
// one-cycle wrap pulse.
// Optional feature macro: UDC_SATURATE_EN -- when defined the counter clamps
// at the range ends instead of wrapping, and Wrap pulses on each clamped step.
module ud_counter_param #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             E,
    input  logic             U,
    input  logic             Ld,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Cnt,
    output logic             Tc,
    output logic             Wrap
);

    // Highest legal count expressed at the counter width.
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_q == MAX_C);
    assign at_zero = (cnt_q == '0);

    // Next-state selection: load beats counting, counting beats hold.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (Ld) begin
            // Clamp loads so an out-of-range count can never be reached.
            cnt_d = (D > MAX_C) ? MAX_C : D;
        end else if (E) begin
            if (U) begin
                if (at_max) begin
`ifdef UDC_SATURATE_EN
                    cnt_d = MAX_C;
`else
                    cnt_d = '0;
`endif
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
`ifdef UDC_SATURATE_EN
                    cnt_d = '0;
`else
                    cnt_d = MAX_C;
`endif
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset overriding load and count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count qualifies the current count for cascading into the next stage.
    assign Tc   = E & ((U & at_max) | (~U & at_zero));
    assign Cnt  = cnt_q;
    assign Wrap = wrap_q;

endmodule
